// File: rtl/mem_arbiter_rr.sv
// Arbiter for the shared main-memory port: BURST_LEN-word line-fill reads and single-word writes.
// Round robin by default; define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_arbiter_rr #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [NUM_CLIENTS-1:0]          req_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic [NUM_CLIENTS-1:0]          rvalid,
    output logic [DATA_W-1:0]               rdata,
    output logic [$clog2(BURST_LEN)-1:0]    rword,
    output logic [NUM_CLIENTS-1:0]          done,
    output logic                            busy,
    output logic                            mem_en,
    output logic                            mem_wr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_valid
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    // Byte offset within a line: words are two bytes wide.
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << (CNT_W + 1)) - 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BURST_LEN - 1);

    // Handshake: a client holds req (with req_wr/addr/wdata stable) until its done pulse;
    // grant is registered one cycle after req is sampled and stays constant until done.
    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic                   rd_hit;
    logic                   done_hit;
    logic [ADDR_W-1:0]      line_base;

    assign any_req   = |req;
    assign line_base = addr_q & ~OFF_MASK;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               cand;

    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_CLIENTS;
            if (!found && req[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && any_req)
            rr_ptr_d = (winner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rd_hit      = 1'b0;
        done_hit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = NUM_CLIENTS'(1) << winner;
                    addr_d      = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d     = req_wdata[int'(winner)*DATA_W +: DATA_W];
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    state_d     = req_wr[winner] ? WR : RD_ISSUE;
                end
            end
            WR: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                done_hit  = 1'b1;
                grant_d   = '0;
                state_d   = IDLE;
            end
            RD_ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = line_base + ADDR_W'({issue_cnt_q, 1'b0});
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_WORD) state_d = RD_DRAIN;
            end
            RD_DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Read data can return while still issuing, so both read states accept it.
        if ((state_q == RD_ISSUE || state_q == RD_DRAIN) && mem_valid) begin
            rd_hit   = 1'b1;
            rx_cnt_d = rx_cnt_q + 1'b1;
            if (rx_cnt_q == LAST_WORD) begin
                done_hit = 1'b1;
                grant_d  = '0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    assign grant  = grant_q;
    assign rvalid = rd_hit   ? grant_q   : '0;
    assign done   = done_hit ? grant_q   : '0;
    assign rdata  = rd_hit   ? mem_rdata : '0;
    assign rword  = rd_hit   ? rx_cnt_q  : '0;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: 2-client instance with a latency-2 memory model, plus a 4-client instance for fairness.
module tb_mem_arbiter_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---- 2-client DUT ----
    logic [1:0]  req = '0, req_wr = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  grant, rvalid, done;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  rword;
    logic        busy, mem_en, mem_wr, mem_valid;

    mem_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_W(16), .DATA_W(16), .BURST_LEN(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
        .rword(rword), .done(done), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    // Pipelined memory: read data = address ^ 16'hA5A5, two cycles after issue.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= mem_en && !mem_wr;
        a1 <= mem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign mem_valid = v2;
    assign mem_rdata = v2 ? (a2 ^ 16'hA5A5) : 16'h0000;

    // ---- 4-client DUT (writes only, no read returns) ----
    logic [3:0]  req4 = '0, req_wr4 = '0;
    logic [63:0] req_addr4 = 64'h0400_0300_0200_0100;
    logic [63:0] req_wdata4 = 64'h4444_3333_2222_1111;
    logic [3:0]  grant4, rvalid4, done4;
    logic [15:0] rdata4, mem_addr4, mem_wdata4;
    logic [2:0]  rword4;
    logic        busy4, mem_en4, mem_wr4;

    mem_arbiter_rr #(.NUM_CLIENTS(4), .ADDR_W(16), .DATA_W(16), .BURST_LEN(8)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_wr(req_wr4), .req_addr(req_addr4),
        .req_wdata(req_wdata4), .grant(grant4), .rvalid(rvalid4), .rdata(rdata4),
        .rword(rword4), .done(done4), .busy(busy4), .mem_en(mem_en4), .mem_wr(mem_wr4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(16'h0000),
        .mem_valid(1'b0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req = '0;
        req4 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_client(input int c, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata);
        req_wr[c]            = wr;
        req_addr[c*16 +: 16]  = addr;
        req_wdata[c*16 +: 16] = wdata;
    endtask

    task automatic do_read(input int c, input logic [15:0] addr, input logic [15:0] base,
                           input string tag);
        logic [15:0] exp_q[$];
        logic [15:0] got_addr_q[$];
        logic [15:0] got_data_q[$];
        logic [2:0]  got_word_q[$];
        int first_iss, last_iss;
        bit seen_done;
        for (int k = 0; k < 8; k++) exp_q.push_back(base + 16'(2 * k));
        set_client(c, 1'b0, addr, 16'h0000);
        req[c] = 1'b1;
        seen_done = 0;
        first_iss = -1;
        last_iss = -1;
        for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check_eq({tag, "_grant"}, 32'(grant), 32'(1 << c));
            if (mem_en) begin
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                got_addr_q.push_back(mem_addr);
            end
            if (rvalid != 2'b00) begin
                check_eq({tag, "_rvalid_owner"}, 32'(rvalid), 32'(1 << c));
                got_word_q.push_back(rword);
                got_data_q.push_back(rdata);
            end
            if (done != 2'b00) begin
                check_eq({tag, "_done_owner"}, 32'(done), 32'(1 << c));
                check_eq({tag, "_done_word"}, 32'(rword), 32'd7);
                seen_done = 1;
                req[c] = 1'b0;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check_eq({tag, "_issue_cnt"}, got_addr_q.size(), 32'd8);
        check_eq({tag, "_issue_span"}, last_iss - first_iss, 32'd7);
        check_eq({tag, "_word_cnt"}, got_word_q.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got_addr_q.size()) check_eq({tag, "_addr"}, 32'(got_addr_q[k]), 32'(exp_q[k]));
            if (k < got_word_q.size()) begin
                check_eq({tag, "_rword"}, 32'(got_word_q[k]), k);
                check_eq({tag, "_rdata"}, 32'(got_data_q[k]), 32'(exp_q[k] ^ 16'hA5A5));
            end
        end
        @(negedge clk);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_grant_after"}, 32'(grant), 32'd0);
    endtask

    initial begin : main
        logic [1:0] exp_q[$];
        logic [1:0] got_q[$];
        logic [3:0] exp4_q[$];
        logic [3:0] got4_q[$];
        int grant_cyc_q[$];
        int first_done_cyc, n_done, nv, n_words;
        logic [1:0] prev_grant;
        logic [3:0] prev_grant4;
        bit done0_seen, wr_seen;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_rword", 32'(rword), 32'd0);
        rst = 1'b0;

        // Single line read and address wrap
        do_reset();
        do_read(1, 16'h0036, 16'h0030, "single");
        do_reset();
        do_read(0, 16'hFFF2, 16'hFFF0, "wrap");

        // Contention: client 0 read, client 1 write
        do_reset();
        set_client(0, 1'b0, 16'h0200, 16'h0000);
        set_client(1, 1'b1, 16'h0100, 16'hBEEF);
        req = 2'b11;
`ifdef ARB_FIXED_PRIO_EN
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
`else
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
`endif
        prev_grant = '0;
        n_done = 0;
        first_done_cyc = -1;
        for (int cyc = 0; cyc < 80 && n_done < 2; cyc++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                got_q.push_back(grant);
                grant_cyc_q.push_back(cyc);
            end
            prev_grant = grant;
            if (mem_wr) begin
                check_eq("cont_wr_addr", 32'(mem_addr), 32'h0100);
                check_eq("cont_wr_data", 32'(mem_wdata), 32'hBEEF);
                check_eq("cont_wr_done", 32'(done), 32'(2'b10));
            end
            if (done != 2'b00) begin
                n_done++;
                if (first_done_cyc < 0) first_done_cyc = cyc;
`ifdef ARB_FIXED_PRIO_EN
                if (n_done == 2) req = 2'b00;
`else
                req = req & ~done;
`endif
            end
        end
        req = 2'b00;
        check_eq("cont_done_cnt", n_done, 32'd2);
        check_eq("cont_grant_cnt", got_q.size(), 32'd2);
        for (int k = 0; k < 2; k++)
            if (k < got_q.size()) check_eq("cont_grant_order", 32'(got_q[k]), 32'(exp_q[k]));
        if (grant_cyc_q.size() > 1)
            check_eq("cont_bubble", grant_cyc_q[1] - first_done_cyc, 32'd2);
        @(negedge clk);
        @(negedge clk);
        check_eq("cont_busy_end", 32'(busy), 32'd0);

        // Fairness on 4 clients, all writing
        do_reset();
        req_wr4 = 4'hF;
        req4 = 4'hF;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++) exp4_q.push_back(4'b0001);
`else
        exp4_q.push_back(4'b0001);
        exp4_q.push_back(4'b0010);
        exp4_q.push_back(4'b0100);
        exp4_q.push_back(4'b1000);
        exp4_q.push_back(4'b0001);
`endif
        prev_grant4 = '0;
        for (int cyc = 0; cyc < 30 && got4_q.size() < 5; cyc++) begin
            @(negedge clk);
            if (grant4 != 4'b0000 && prev_grant4 == 4'b0000) begin
                got4_q.push_back(grant4);
                check_eq("fair_onehot", 32'($onehot(grant4)), 32'd1);
            end
            prev_grant4 = grant4;
        end
        req4 = '0;
        check_eq("fair_grant_cnt", got4_q.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < got4_q.size()) check_eq("fair_order", 32'(got4_q[k]), 32'(exp4_q[k]));

        // Reset in the middle of a burst
        do_reset();
        set_client(0, 1'b0, 16'h0040, 16'h0000);
        req = 2'b01;
        nv = 0;
        for (int cyc = 0; cyc < 40 && nv < 3; cyc++) begin
            @(negedge clk);
            if (rvalid[0]) nv++;
            check_eq("rstmid_no_done", 32'(done), 32'd0);
        end
        check_eq("rstmid_valid_cnt", nv, 32'd3);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check_eq("rstmid_grant", 32'(grant), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_eq("rstmid_late_rvalid", 32'(rvalid), 32'd0);
            check_eq("rstmid_late_done", 32'(done), 32'd0);
        end

        // Client 0 drops req after grant; client 1 write pending
        do_reset();
        set_client(0, 1'b0, 16'h0080, 16'h0000);
        set_client(1, 1'b1, 16'h0110, 16'h1234);
        req = 2'b11;
        @(negedge clk);
        check_eq("drop_grant0", 32'(grant), 32'(2'b01));
        req[0] = 1'b0;
        n_words = 0;
        done0_seen = 0;
        wr_seen = 0;
        for (int cyc = 0; cyc < 60 && !wr_seen; cyc++) begin
            @(negedge clk);
            if (rvalid[0]) n_words++;
            if (done[0]) done0_seen = 1;
            if (mem_wr) begin
                wr_seen = 1;
                check_eq("drop_wr_grant", 32'(grant), 32'(2'b10));
                check_eq("drop_wr_addr", 32'(mem_addr), 32'h0110);
                check_eq("drop_wr_data", 32'(mem_wdata), 32'h1234);
                check_eq("drop_wr_done", 32'(done), 32'(2'b10));
                req[1] = 1'b0;
            end
        end
        check_eq("drop_words", n_words, 32'd8);
        check_eq("drop_done0", 32'(done0_seen), 32'd1);
        check_eq("drop_wr_seen", 32'(wr_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
